// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with debounce and valid/ack key output
// One column is driven low per scan tick; a single low row is debounced, encoded and offered once.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overflow
);
  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED} state_e;

  state_e          state_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [3:0]      row_meta_q, rs_q;
  logic [3:0]      col_q;
  logic [1:0]      col_idx_q, row_idx_q;
  logic [DW-1:0]   dcnt_q;
  logic            key_down_q;
  logic            acc_q;
  logic [3:0]      acc_code_q;
  logic [3:0]      key_code_q;
  logic            key_valid_q;
  logic            overflow_q;

  logic            tick;
  logic            row_hit;
  logic [1:0]      row_sel;
  logic [3:0]      col_rot;
  logic [DW-1:0]   dcnt_inc;
  logic            dcnt_done;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;
      4'h1: key_map = 4'h2;
      4'h2: key_map = 4'h3;
      4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;
      4'h5: key_map = 4'h5;
      4'h6: key_map = 4'h6;
      4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;
      4'h9: key_map = 4'h8;
      4'hA: key_map = 4'h9;
      4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;
      4'hD: key_map = 4'hF;
      4'hE: key_map = 4'hE;
      default: key_map = 4'hD;
    endcase
  endfunction

  assign tick      = (tick_cnt_q == TW'(SCAN_DIV - 1));
  assign col_rot   = {col_q[2:0], col_q[3]};
  assign dcnt_inc  = dcnt_q + DW'(1);
  assign dcnt_done = (dcnt_inc == DW'(DEBOUNCE_SCANS));

  // Zero or several low rows (ghosting) never count as a key.
  always_comb begin
    row_hit = 1'b1;
    row_sel = 2'd0;
    case (rs_q)
      4'b1110: row_sel = 2'd0;
      4'b1101: row_sel = 2'd1;
      4'b1011: row_sel = 2'd2;
      4'b0111: row_sel = 2'd3;
      default: row_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      row_meta_q <= 4'b1111;
      rs_q       <= 4'b1111;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      row_meta_q <= row;
      rs_q       <= row_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_SCAN;
      col_q      <= 4'b1110;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
      dcnt_q     <= '0;
      key_down_q <= 1'b0;
      acc_q      <= 1'b0;
      acc_code_q <= 4'h0;
    end else begin
      acc_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_SCAN: begin
            if (row_hit) begin
              row_idx_q <= row_sel;
              if (DEBOUNCE_SCANS <= 1) begin
                state_q    <= S_PRESSED;
                key_down_q <= 1'b1;
                dcnt_q     <= '0;
                acc_q      <= 1'b1;
                acc_code_q <= key_map(row_sel, col_idx_q);
              end else begin
                state_q <= S_DEBOUNCE;
                dcnt_q  <= DW'(1);
              end
            end else begin
              col_q     <= col_rot;
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          S_DEBOUNCE: begin
            if (row_hit && row_sel == row_idx_q) begin
              if (dcnt_done) begin
                state_q    <= S_PRESSED;
                key_down_q <= 1'b1;
                dcnt_q     <= '0;
                acc_q      <= 1'b1;
                acc_code_q <= key_map(row_idx_q, col_idx_q);
              end else begin
                dcnt_q <= dcnt_inc;
              end
            end else begin
              state_q   <= S_SCAN;
              dcnt_q    <= '0;
              col_q     <= col_rot;
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          default: begin
            // dcnt now counts consecutive all-released samples.
            if (rs_q == 4'b1111) begin
              if (dcnt_done) begin
                state_q    <= S_SCAN;
                key_down_q <= 1'b0;
                dcnt_q     <= '0;
                col_q      <= col_rot;
                col_idx_q  <= col_idx_q + 2'd1;
              end else begin
                dcnt_q <= dcnt_inc;
              end
            end else begin
              dcnt_q <= '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (acc_q) begin
      if (!key_valid_q || key_ack) begin
        key_code_q  <= acc_code_q;
        key_valid_q <= 1'b1;
      end else begin
        overflow_q <= 1'b1;
      end
    end else if (key_ack && key_valid_q) begin
      key_valid_q <= 1'b0;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized bench for keypad_scanner against a per-tick keypad reference model
module tb_keypad_scanner;
  localparam int DB      = 3;
  localparam int HUNT    = 0;
  localparam int CONFIRM = 1;
  localparam int HELD    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_ack;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic        overflow;
  logic [15:0] press;

  int          n_checks = 0;
  int          n_pass   = 0;

  logic [3:0]  keymap [16];
  int          m_mode, m_col, m_row, m_agree, m_rel;
  bit          m_pend, m_valid, m_ovf;
  logic [3:0]  m_pcode, m_code;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_down(key_down), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(press[r*4 +: 4] & ~col);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_mode = HUNT; m_col = 0; m_row = 0; m_agree = 0; m_rel = 0;
    m_pend = 0; m_valid = 0; m_ovf = 0; m_pcode = 4'h0; m_code = 4'h0;
  endtask

  task automatic model_tick();
    int lows, lr;
    lows = 0; lr = 0;
    for (int r = 0; r < 4; r++) if (press[r*4 + m_col]) begin lows++; lr = r; end
    case (m_mode)
      HUNT: begin
        if (lows == 1) begin m_row = lr; m_agree = 1; m_mode = CONFIRM; end
        else m_col = (m_col + 1) % 4;
      end
      CONFIRM: begin
        if (lows == 1 && lr == m_row) begin
          m_agree++;
          if (m_agree == DB) begin
            m_mode = HELD; m_rel = 0; m_pend = 1; m_pcode = keymap[m_row*4 + m_col];
          end
        end else begin
          m_col = (m_col + 1) % 4; m_mode = HUNT;
        end
      end
      default: begin
        if (lows == 0) begin
          m_rel++;
          if (m_rel == DB) begin m_col = (m_col + 1) % 4; m_mode = HUNT; end
        end else m_rel = 0;
      end
    endcase
  endtask

  task automatic model_hs(input bit ack);
    if (m_pend) begin
      if (!m_valid || ack) begin m_code = m_pcode; m_valid = 1; end
      else m_ovf = 1;
      m_pend = 0;
    end else if (ack && m_valid) m_valid = 0;
  endtask

  // One scan period: tick edge, stimulus update, accept edge, compare, two idle edges.
  task automatic one_tick(input logic [15:0] p, input bit ack);
    logic [3:0] cv;
    @(posedge clk);
    model_tick();
    #1; press = p; key_ack = ack;
    @(posedge clk);
    model_hs(ack);
    #1; key_ack = 1'b0;
    cv = 4'hF; cv[m_col] = 1'b0;
    chk("col", 32'(col), 32'(cv));
    chk("key_down", 32'(key_down), 32'(m_mode == HELD));
    chk("key_valid", 32'(key_valid), 32'(m_valid));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_valid) chk("key_code", 32'(key_code), 32'(m_code));
    repeat (2) @(posedge clk);
  endtask

  task automatic run_ticks(input int n, input logic [15:0] p, input bit ack);
    for (int i = 0; i < n; i++) one_tick(p, ack);
  endtask

  task automatic do_reset();
    #2; reset = 1'b1; press = '0; key_ack = 1'b0;
    #1;
    chk("rst_col", 32'(col), 32'hE);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_down", 32'(key_down), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
  endtask

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] v;
    v = '0; v[r*4 + c] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [15:0] rp;
    int k;
    keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    reset = 1'b1; key_ack = 1'b0; press = '0;
    model_reset();
    do_reset();

    run_ticks(10, key(1, 1), 1'b0);
    chk("t1_code", 32'(key_code), 32'h5);
    chk("t1_valid", 32'(key_valid), 32'h1);
    chk("t1_col", 32'(col), 32'hD);
    run_ticks(50, key(1, 1), 1'b0);
    run_ticks(1, key(1, 1), 1'b1);
    chk("t2_cleared", 32'(key_valid), 32'h0);
    run_ticks(8, '0, 1'b0);

    for (int i = 0; i < 6; i++) one_tick((i % 2 == 0) ? key(3, 2) : 16'h0, 1'b0);
    run_ticks(10, key(3, 2), 1'b0);
    chk("t3_code", 32'(key_code), 32'hE);
    run_ticks(1, key(3, 2), 1'b1);
    run_ticks(6, '0, 1'b0);

    run_ticks(8, key(0, 0), 1'b0);
    run_ticks(6, '0, 1'b0);
    run_ticks(8, key(2, 3), 1'b0);
    run_ticks(6, '0, 1'b0);
    chk("t4_code_kept", 32'(key_code), 32'h1);
    chk("t4_overflow", 32'(overflow), 32'h1);
    run_ticks(1, '0, 1'b1);
    run_ticks(8, key(3, 0), 1'b0);
    chk("t4_code_new", 32'(key_code), 32'h0);
    run_ticks(1, key(3, 0), 1'b1);
    run_ticks(6, '0, 1'b0);

    run_ticks(20, key(0, 1) | key(1, 1), 1'b0);
    chk("t5_no_valid", 32'(key_valid), 32'h0);
    run_ticks(6, '0, 1'b0);

    do_reset();
    run_ticks(4, key(2, 2), 1'b0);
    chk("t6_in_debounce_col", 32'(col), 32'hB);
    do_reset();
    run_ticks(8, key(0, 3), 1'b0);
    chk("t6_valid_before", 32'(key_valid), 32'h1);
    do_reset();

    rp = '0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        k = int'($urandom_range(0, 3));
        rp = '0;
        if (k == 1 || k == 2) rp[$urandom_range(0, 15)] = 1'b1;
        else if (k == 3) begin
          rp[$urandom_range(0, 15)] = 1'b1;
          rp[$urandom_range(0, 15)] = 1'b1;
        end
      end
      one_tick(rp, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
